// File: rtl/controller_mc_v_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU codes,
// data-processing cmd codes and datapath mux select values.
package controller_mc_v_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_EOR  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic cmd_defined(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR,
      CMD_EOR, CMD_MOV, CMD_CMP: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      CMD_EOR:          return ALU_EOR;
      CMD_MOV:          return ALU_PASS;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controller_mc_v_condcheck.sv
// ARM condition-code evaluation against registered NZCV flags.
module mc_condcheck_v (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v, ge;

  always_comb begin
    {n, z, c, v} = flags;
    ge = (n == v);
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z & ge;
      4'b1101: cond_ex = z | ~ge;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/controller_mc_v.sv
// Multicycle ARM control unit: Moore FSM over FETCH/DECODE/execute/writeback,
// NZCV flag register, and all datapath selects/enables.
module controller_mc_v
  import controller_mc_v_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic        InstrDone
);
  state_t     state, state_nxt;
  logic [3:0] flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd, cond;
  logic       rd_pc, is_cmp, undef, cond_ex, in_exec;
  logic       pc_wr, mem_wr, ir_wr, reg_wr, done;

  assign cond   = Instr[19:16];
  assign op     = Instr[15:14];
  assign funct  = Instr[13:8];
  assign cmd    = funct[4:1];
  assign rd_pc  = (Instr[3:0] == 4'hF);
  assign is_cmp = (cmd == CMD_CMP);
  assign undef  = (op == 2'b11) || ((op == OP_DP) && !cmd_defined(cmd));
  assign in_exec = (state == S_EXECUTER) || (state == S_EXECUTEI);

  mc_condcheck_v u_condcheck (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      flags <= FLAG_RST;
    end else begin
      state <= state_nxt;
      // N/Z follow any S-suffixed op; C/V only come from the adder paths.
      if (in_exec && funct[0]) begin
        flags[3:2] <= ALUFlags[3:2];
        if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (cond_ex && !undef) begin
          case (op)
            OP_DP:   state_nxt = funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_MEM:  state_nxt = S_MEMADR;
            OP_BR:   state_nxt = S_BRANCH;
            default: state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: state_nxt = is_cmp ? S_FETCH : S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_wr      = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_wr     = 1'b1;
        pc_wr     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        done      = !cond_ex || undef;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        done      = 1'b1;
        pc_wr     = rd_pc;
        reg_wr    = !rd_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        done   = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
        ALUControl = alu_for_cmd(cmd);
        done       = is_cmp;
      end
      S_ALUWB: begin
        done   = 1'b1;
        pc_wr  = rd_pc;
        reg_wr = !rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_wr     = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite   = pc_wr  & reset;
  assign MemWrite  = mem_wr & reset;
  assign IRWrite   = ir_wr  & reset;
  assign RegWrite  = reg_wr & reset;
  assign InstrDone = done   & reset;

  assign ImmSrc    = op;
  assign RegSrc[0] = (op == OP_BR);
  assign RegSrc[1] = (op == OP_MEM) && !funct[0];

endmodule

// File: tb/tb_controller_mc_v.sv
// Directed per-cycle vector bench for controller_mc_v.
module tb_controller_mc_v;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [2:0] alu;
    logic       done;
  } outs_t;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  aluflags;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, InstrDone;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
  logic [2:0]  ALUControl;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  controller_mc_v #(.FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .InstrDone(InstrDone)
  );

  function automatic outs_t o(logic pcw, logic adr, logic memw, logic irw, logic regw,
                              logic [1:0] regsrc, logic [1:0] immsrc, logic srca,
                              logic [1:0] srcb, logic [1:0] res, logic [2:0] alu,
                              logic done);
    outs_t r;
    r = '{pcw, adr, memw, irw, regw, regsrc, immsrc, srca, srcb, res, alu, done};
    return r;
  endfunction

  function automatic outs_t f_o(logic [1:0] rs, logic [1:0] is);
    return o(1, 0, 0, 1, 0, rs, is, 1, 2'b10, 2'b10, 3'b000, 0);
  endfunction

  function automatic outs_t d_o(logic [1:0] rs, logic [1:0] is, logic done);
    return o(0, 0, 0, 0, 0, rs, is, 1, 2'b10, 2'b10, 3'b000, done);
  endfunction

  function automatic outs_t actual();
    return o(PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ALUControl, InstrDone);
  endfunction

  task automatic add(input logic [19:0] i, input logic [3:0] f, input outs_t e);
    vec_t v;
    v.instr = i;
    v.aluflags = f;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input outs_t e);
    outs_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", name, a, e);
    end
  endtask

  task automatic run_row(input string name, input vec_t v);
    @(negedge clk);
    Instr = v.instr;
    ALUFlags = v.aluflags;
    #1;
    compare(name, v.exp);
  endtask

  initial begin
    // ADD R1,R2,R3
    add(20'hE0821, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE0821, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE0821, 4'h0, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b000, 0));
    add(20'hE0821, 4'h0, o(0,0,0,0,1, 2'b00,2'b00, 0,2'b00,2'b00,3'b000, 1));
    // LDR R0,[R1,#4]
    add(20'hE5910, 4'h0, f_o(2'b00, 2'b01));
    add(20'hE5910, 4'h0, d_o(2'b00, 2'b01, 0));
    add(20'hE5910, 4'h0, o(0,0,0,0,0, 2'b00,2'b01, 0,2'b01,2'b00,3'b000, 0));
    add(20'hE5910, 4'h0, o(0,1,0,0,0, 2'b00,2'b01, 0,2'b00,2'b00,3'b000, 0));
    add(20'hE5910, 4'h0, o(0,0,0,0,1, 2'b00,2'b01, 0,2'b00,2'b01,3'b000, 1));
    // STR R0,[R1,#4]
    add(20'hE5810, 4'h0, f_o(2'b10, 2'b01));
    add(20'hE5810, 4'h0, d_o(2'b10, 2'b01, 0));
    add(20'hE5810, 4'h0, o(0,0,0,0,0, 2'b10,2'b01, 0,2'b01,2'b00,3'b000, 0));
    add(20'hE5810, 4'h0, o(0,1,1,0,0, 2'b10,2'b01, 0,2'b00,2'b00,3'b000, 1));
    // CMP R1,R1 with ALUFlags 0110 -> Flags 0110
    add(20'hE1510, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE1510, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE1510, 4'h6, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b001, 1));
    // BEQ taken
    add(20'h0A000, 4'h0, f_o(2'b01, 2'b10));
    add(20'h0A000, 4'h0, d_o(2'b01, 2'b10, 0));
    add(20'h0A000, 4'h0, o(1,0,0,0,0, 2'b01,2'b10, 0,2'b01,2'b10,3'b000, 1));
    // MOV PC,R3
    add(20'hE1A0F, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE1A0F, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE1A0F, 4'h0, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b101, 0));
    add(20'hE1A0F, 4'h0, o(1,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b000, 1));
    // CMP with ALUFlags 0000 -> Flags 0000, then BEQ untaken (2 cycles)
    add(20'hE1510, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE1510, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE1510, 4'h0, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b001, 1));
    add(20'h0A000, 4'h0, f_o(2'b01, 2'b10));
    add(20'h0A000, 4'h0, d_o(2'b01, 2'b10, 1));
    // Undefined Op=11 retires from DECODE
    add(20'hEC000, 4'h0, f_o(2'b00, 2'b11));
    add(20'hEC000, 4'h0, d_o(2'b00, 2'b11, 1));
    // CMP with C=1 -> Flags 0010
    add(20'hE1510, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE1510, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE1510, 4'h2, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b001, 1));
    // ANDS R0,R0,R0 with ALUFlags 1001 -> Flags 1010 (C kept, V not taken)
    add(20'hE0100, 4'h0, f_o(2'b00, 2'b00));
    add(20'hE0100, 4'h0, d_o(2'b00, 2'b00, 0));
    add(20'hE0100, 4'h9, o(0,0,0,0,0, 2'b00,2'b00, 0,2'b00,2'b00,3'b010, 0));
    add(20'hE0100, 4'h0, o(0,0,0,0,1, 2'b00,2'b00, 0,2'b00,2'b00,3'b000, 1));
    // BCS taken (C=1)
    add(20'h2A000, 4'h0, f_o(2'b01, 2'b10));
    add(20'h2A000, 4'h0, d_o(2'b01, 2'b10, 0));
    add(20'h2A000, 4'h0, o(1,0,0,0,0, 2'b01,2'b10, 0,2'b01,2'b10,3'b000, 1));
    // BVS untaken (V=0)
    add(20'h6A000, 4'h0, f_o(2'b01, 2'b10));
    add(20'h6A000, 4'h0, d_o(2'b01, 2'b10, 1));
    // BMI taken (N=1), still from flags set by ANDS
    add(20'h4A000, 4'h0, f_o(2'b01, 2'b10));
    add(20'h4A000, 4'h0, d_o(2'b01, 2'b10, 0));
    add(20'h4A000, 4'h0, o(1,0,0,0,0, 2'b01,2'b10, 0,2'b01,2'b10,3'b000, 1));

    // Reset state: enables gated, FETCH selects visible
    Instr = 20'hE0821;
    repeat (2) @(posedge clk);
    #1;
    compare("reset_hold", o(0,0,0,0,0, 2'b00,2'b00, 1,2'b10,2'b10,3'b000, 0));
    #1 reset = 1'b1;

    foreach (tbl[k]) run_row($sformatf("row%0d", k), tbl[k]);

    // Reset pulled low in the middle of MEMWR
    for (int unsigned k = 9; k <= 12; k++) run_row($sformatf("rst_str%0d", k), tbl[k]);
    #2 reset = 1'b0;
    #1 compare("rst_mid_memwr", o(0,0,0,0,0, 2'b10,2'b01, 1,2'b10,2'b10,3'b000, 0));
    @(posedge clk);
    #2 reset = 1'b1;
    begin
      vec_t v;
      v.instr = 20'h4A000;
      v.aluflags = 4'h0;
      v.exp = f_o(2'b01, 2'b10);
      run_row("rst_fetch", v);
      // Flags back to 0000: BMI now untaken
      v.exp = d_o(2'b01, 2'b10, 1);
      run_row("rst_flags", v);
      v.exp = f_o(2'b01, 2'b10);
      run_row("rst_refetch", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
